// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result collector: flag layout, op codes,
// the default result-entry type and the result FIFO state encoding.
package fpu_pkg;

  localparam int FLAG_W = 3;

  // Bit positions inside a packed flag word {Exception, Overflow, Underflow}
  localparam int FLG_EXC = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  localparam int RES_DATA_W = 32;
  localparam int RES_OP_W   = 4;

  localparam logic [RES_OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [RES_OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [RES_OP_W-1:0] OP_MUL = 4'd2;
  localparam logic [RES_OP_W-1:0] OP_DIV = 4'd3;

  // Default shape of one buffered result (collector narrows/widens it locally)
  typedef struct packed {
    logic [RES_DATA_W-1:0] data;
    logic [FLAG_W-1:0]     flags;
    logic [RES_OP_W-1:0]   op;
  } res_entry_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_t;

  // Pack the three core flag wires into the shared flag-word layout
  function automatic logic [FLAG_W-1:0] pack_flags(input logic exc, input logic ovf,
                                                   input logic unf);
    logic [FLAG_W-1:0] f;
    f          = '0;
    f[FLG_EXC] = exc;
    f[FLG_OVF] = ovf;
    f[FLG_UNF] = unf;
    return f;
  endfunction

endpackage

// File: rtl/fpu_result_collector_if.sv
// Issue / core-result / consumer bundle of the FPU result collector.
// Res_Op exists only when FPU_RES_OPTAG_EN is defined.
interface fpu_result_collector_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              Issue_Valid;
  logic [OP_W-1:0]   Issue_Op;
  logic              Issue_Ready;
  logic [DATA_W-1:0] FPU_Output;
  logic              Exception;
  logic              Overflow;
  logic              Underflow;
  logic              Res_Valid;
  logic              Res_Ready;
  logic [DATA_W-1:0] Res_Data;
  logic [2:0]        Res_Flags;
`ifdef FPU_RES_OPTAG_EN
  logic [OP_W-1:0]   Res_Op;
`endif
  logic [2:0]        Sticky_Flags;
  logic              Flags_Clear;
  logic              Drop_Err;
  logic [CNT_W-1:0]  Count;

  // Issuer / core / consumer side
  modport master (
    output Issue_Valid, Issue_Op, FPU_Output, Exception, Overflow, Underflow,
    output Res_Ready, Flags_Clear,
    input  Issue_Ready, Res_Valid, Res_Data, Res_Flags,
`ifdef FPU_RES_OPTAG_EN
    input  Res_Op,
`endif
    input  Sticky_Flags, Drop_Err, Count
  );

  // Collector side
  modport slave (
    input  Issue_Valid, Issue_Op, FPU_Output, Exception, Overflow, Underflow,
    input  Res_Ready, Flags_Clear,
    output Issue_Ready, Res_Valid, Res_Data, Res_Flags,
`ifdef FPU_RES_OPTAG_EN
    output Res_Op,
`endif
    output Sticky_Flags, Drop_Err, Count
  );

endinterface

// File: rtl/fpu_res_fifo.sv
// Show-ahead synchronous FIFO for captured FPU results. The head entry is
// read straight out of the storage array so it is valid in the cycle after
// the push edge. Occupancy is tracked by an EMPTY/PARTIAL/FULL state machine.
module fpu_res_fifo
  import fpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = res_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output logic             valid,
  output entry_t           dout,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  fifo_state_t       state;
  logic              push_ok;
  logic              pop_ok;

  // A full FIFO only accepts a push when the head leaves in the same cycle
  assign pop_ok  = pop & (state != FIFO_EMPTY);
  assign push_ok = push & ((state != FIFO_FULL) | pop_ok);

  // Occupancy state machine plus pointers and count; pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FIFO_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok) count <= count + CNT_W'(1);
      if (pop_ok && !push_ok) count <= count - CNT_W'(1);
      case (state)
        FIFO_EMPTY: begin
          if (push_ok) state <= FIFO_PARTIAL;
        end
        FIFO_PARTIAL: begin
          if (push_ok && !pop_ok && count == CNT_W'(DEPTH - 1)) state <= FIFO_FULL;
          else if (pop_ok && !push_ok && count == CNT_W'(1))    state <= FIFO_EMPTY;
        end
        FIFO_FULL: begin
          if (pop_ok && !push_ok) state <= FIFO_PARTIAL;
        end
        default: state <= FIFO_EMPTY;
      endcase
    end
  end

  // Result storage; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign valid = (state != FIFO_EMPTY);
  assign full  = (state == FIFO_FULL);

endmodule

// File: rtl/fpu_result_collector.sv
// FPU result collector: follows issued ops through a fixed-latency valid
// pipe, captures the core result and flags when the pipe's last stage fires,
// buffers them in a show-ahead FIFO and keeps sticky flag / drop status.
// Issue_Ready grants a credit only when every in-flight op is guaranteed a
// FIFO slot. Optional op tagging is enabled with FPU_RES_OPTAG_EN.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
) (
  input logic                   Clk,
  input logic                   Rst,
  fpu_result_collector_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

`ifdef FPU_RES_OPTAG_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
    logic [OP_W-1:0]   op;
  } entry_t;
`else
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } entry_t;
`endif

  logic [LATENCY-1:0] vpipe;
  logic               capture;
  logic               push;
  logic               pop;
  logic               drop;
  logic [FLAG_W-1:0]  cap_flags;
  entry_t             cap_entry;
  entry_t             head;
  logic               fifo_valid;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   committed;
  logic [FLAG_W-1:0]  sticky;
  logic               drop_err;

  // First valid-pipe stage samples the issue strobe
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) vpipe[0] <= 1'b0;
    else     vpipe[0] <= bus.Issue_Valid;
  end

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vstage
    // Remaining valid-pipe stages shift the strobe toward the capture point
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) vpipe[gi] <= 1'b0;
      else     vpipe[gi] <= vpipe[gi-1];
    end
  end

  assign capture   = vpipe[LATENCY-1];
  assign cap_flags = pack_flags(bus.Exception, bus.Overflow, bus.Underflow);

`ifdef FPU_RES_OPTAG_EN
  logic [OP_W-1:0] opipe [LATENCY];

  // First op-pipe stage travels alongside the issue strobe
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) opipe[0] <= '0;
    else     opipe[0] <= bus.Issue_Op;
  end

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_ostage
    // Remaining op-pipe stages
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) opipe[gi] <= '0;
      else     opipe[gi] <= opipe[gi-1];
    end
  end

  assign cap_entry  = '{data: bus.FPU_Output, flags: cap_flags, op: opipe[LATENCY-1]};
  assign bus.Res_Op = head.op;
`else
  logic unused_op;
  assign unused_op = ^bus.Issue_Op;
  assign cap_entry = '{data: bus.FPU_Output, flags: cap_flags};
`endif

  // A capture into a full FIFO is still accepted when the head leaves now
  assign pop  = fifo_valid & bus.Res_Ready;
  assign push = capture & (~fifo_full | pop);
  assign drop = capture & fifo_full & ~pop;

  fpu_res_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push),
    .pop   (pop),
    .din   (cap_entry),
    .valid (fifo_valid),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Credit check: buffered plus in-flight results must leave a free slot
  assign committed       = SUM_W'(fifo_count) + SUM_W'($countones(vpipe));
  assign bus.Issue_Ready = (committed < SUM_W'(DEPTH));

  // Sticky flags and drop status; a same-cycle capture wins over a clear
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sticky   <= '0;
      drop_err <= 1'b0;
    end else begin
      sticky   <= (bus.Flags_Clear ? '0 : sticky) | (capture ? cap_flags : '0);
      drop_err <= (bus.Flags_Clear ? 1'b0 : drop_err) | drop;
    end
  end

  assign bus.Res_Valid    = fifo_valid;
  assign bus.Res_Data     = head.data;
  assign bus.Res_Flags    = head.flags;
  assign bus.Sticky_Flags = sticky;
  assign bus.Drop_Err     = drop_err;
  assign bus.Count        = fifo_count;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed + light random bench for fpu_result_collector (LATENCY=1).
// Expected results are queued at capture time and compared at the FIFO head.
module tb_fpu_result_collector;
  import fpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 1;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  fpu_result_collector_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  fpu_result_collector #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .DATA_W(DATA_W), .OP_W(OP_W)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    logic [3:0]  op;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       cap_v;
  exp_t       cap_e;
  logic [2:0] m_sticky;
  logic       m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs that must hold whenever the collector is idle after reset
  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, 32'(bus.Count), 0);
    chk({tag, "_res_valid"}, 32'(bus.Res_Valid), 0);
    chk({tag, "_sticky"}, 32'(bus.Sticky_Flags), 0);
    chk({tag, "_drop_err"}, 32'(bus.Drop_Err), 0);
    chk({tag, "_issue_ready"}, 32'(bus.Issue_Ready), 1);
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks at negedge,
  // advances the model, returns at the next posedge+1.
  task automatic tick(input logic iv, input logic [3:0] op, input logic [31:0] d,
                      input logic [2:0] f, input logic rdy, input logic clr);
    logic dropped;
    int   size_now;
    bus.Issue_Valid = iv;
    bus.Issue_Op    = op;
    bus.Res_Ready   = rdy;
    bus.Flags_Clear = clr;
    bus.FPU_Output  = cap_v ? cap_e.data : 32'hDEAD_BEEF;
    {bus.Exception, bus.Overflow, bus.Underflow} = cap_v ? cap_e.flags : 3'b111;
    @(negedge Clk);
    size_now = sb.size();
    chk("count", 32'(bus.Count), 32'(size_now));
    chk("res_valid", 32'(bus.Res_Valid), 32'(size_now != 0));
    chk("issue_ready", 32'(bus.Issue_Ready), 32'((size_now + int'(cap_v)) < DEPTH));
    chk("sticky", 32'(bus.Sticky_Flags), 32'(m_sticky));
    chk("drop_err", 32'(bus.Drop_Err), 32'(m_drop));
    if (size_now != 0) begin
      chk("res_data", bus.Res_Data, sb[0].data);
      chk("res_flags", 32'(bus.Res_Flags), 32'(sb[0].flags));
`ifdef FPU_RES_OPTAG_EN
      chk("res_op", 32'(bus.Res_Op), 32'(sb[0].op));
`endif
      if (rdy) begin
        $display("pop  data=%h flags=%b op=%0d", sb[0].data, sb[0].flags, sb[0].op);
        void'(sb.pop_front());
      end
    end
    dropped = 1'b0;
    if (cap_v) begin
      if (sb.size() < DEPTH) sb.push_back(cap_e);
      else begin
        dropped = 1'b1;
        $display("drop data=%h flags=%b", cap_e.data, cap_e.flags);
      end
    end
    m_sticky = (clr ? 3'b000 : m_sticky) | (cap_v ? cap_e.flags : 3'b000);
    m_drop   = (clr ? 1'b0 : m_drop) | dropped;
    cap_v    = iv;
    cap_e    = '{data: d, flags: f, op: op};
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic       iv_r;
    logic [2:0] f_r;
    cap_v    = 1'b0;
    cap_e    = '{data: 32'h0, flags: 3'b000, op: 4'h0};
    m_sticky = 3'b000;
    m_drop   = 1'b0;
    bus.Issue_Valid = 1'b0;
    bus.Issue_Op    = '0;
    bus.Res_Ready   = 1'b0;
    bus.Flags_Clear = 1'b0;
    bus.FPU_Output  = '0;
    bus.Exception   = 1'b0;
    bus.Overflow    = 1'b0;
    bus.Underflow   = 1'b0;

    // Reset state
    #12;
    chk_idle("reset");
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // Single op: result visible two cycles after issue
    tick(1'b1, OP_ADD, 32'h4097_3333, 3'b000, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);

    // Back-pressure fill: credits run out after four issues, then drain in order
    for (int i = 0; i < 4; i++)
      tick(1'b1, 4'(i), 32'h1000 + 32'(i), 3'b000, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);

    // Full FIFO with a capture and a pop in the same cycle
    for (int i = 0; i < 4; i++)
      tick(1'b1, OP_MUL, 32'h2000 + 32'(i), 3'b000, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);
    tick(1'b1, OP_DIV, 32'hAAAA_0001, 3'b000, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);

    // Forced drop into a full FIFO with no pop
    tick(1'b1, OP_SUB, 32'h7F80_0000, 3'b110, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);

    // Sticky flags accumulate, then a clear coinciding with a capture
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b1);
    tick(1'b1, OP_ADD, 32'h3000_0001, 3'b010, 1'b1, 1'b0);
    tick(1'b1, OP_SUB, 32'h3000_0002, 3'b001, 1'b1, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);
    tick(1'b1, OP_MUL, 32'h3000_0003, 3'b100, 1'b1, 1'b0);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b1);
    tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);

    // Async reset with two buffered results and one still in flight
    tick(1'b1, OP_ADD, 32'h4000_0001, 3'b001, 1'b0, 1'b0);
    tick(1'b1, OP_ADD, 32'h4000_0002, 3'b001, 1'b0, 1'b0);
    tick(1'b1, OP_ADD, 32'h4000_0003, 3'b001, 1'b0, 1'b0);
    bus.Issue_Valid = 1'b0;
    bus.Res_Ready   = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    chk_idle("async_rst");
    #2;
    Rst = 1'b0;
    sb.delete();
    cap_v    = 1'b0;
    m_sticky = 3'b000;
    m_drop   = 1'b0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b0, 1'b0);

    // Random traffic honouring the credit rule
    for (int i = 0; i < 60; i++) begin
      iv_r = ((sb.size() + int'(cap_v)) < DEPTH) && ($urandom_range(0, 1) == 1);
      f_r  = 3'($urandom_range(0, 7));
      tick(iv_r, 4'($urandom_range(0, 15)), $urandom, f_r,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 6; i++) tick(1'b0, OP_ADD, 32'h0, 3'b000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
Downstream stage of the FPU core. It tracks operations issued to the core through a fixed-latency valid pipe and captures the core's result word and exception/overflow/underflow flags when they emerge. Captured results are buffered in a small FIFO with a valid/ready consumer interface. It also keeps sticky accumulated flags. Credit-based Issue_Ready back-pressures the issuer so that a result is never lost.

Parameters:
DEPTH, 4, result FIFO entries (power of two, >=2)
LATENCY, 1, cycles from Issue_Valid to FPU_Output/flags valid (>=1)
DATA_W, 32, result width
OP_W, 4, operation code width

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous active-high reset
Issue_Valid  input  1  operation presented to FPU core this cycle
Issue_Op  input  OP_W  operation code of issued op
Issue_Ready  output  1  issuer may assert Issue_Valid this cycle
FPU_Output  input  DATA_W  core result
Exception  input  1  core exception flag
Overflow  input  1  core overflow flag
Underflow  input  1  core underflow flag
Res_Valid  output  1  FIFO head valid
Res_Ready  input  1  consumer accepts head
Res_Data  output  DATA_W  head result
Res_Flags  output  3  head flags {Exception,Overflow,Underflow}
Res_Op  output  OP_W  head op code (only with FPU_RES_OPTAG_EN)
Sticky_Flags  output  3  OR of flags of all captured results since clear
Flags_Clear  input  1  clear Sticky_Flags and Drop_Err
Drop_Err  output  1  sticky: a result arrived with FIFO full
Count  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, Rst=1): valid pipe, op pipe, FIFO pointers, Count, Sticky_Flags and Drop_Err all go to 0. Res_Valid=0. Issue_Ready=1 once Rst deasserts. Results still in flight are discarded.
- Valid pipe: LATENCY-stage shift register of Issue_Valid. Issue_Op travels alongside it when the macro is defined. Capture occurs in the cycle where the last stage is 1; FPU_Output and flags are sampled at that edge.
- Timing, LATENCY=1: Issue_Valid in cycle t, capture at end of t+1, Res_Valid=1 in t+2. Show-ahead FIFO; outputs are driven from registered storage.
- Inflight = popcount of the valid pipe. Issue_Ready = (Count + Inflight) < DEPTH, combinational.
- Issue_Valid while Issue_Ready=0 is a protocol violation. It is still tracked.
- Pop: Res_Valid & Res_Ready.
- Push: capture & (Count<DEPTH or pop).
- Simultaneous push and pop leaves Count unchanged, including when full.
- Capture with Count==DEPTH and no pop: the result is discarded, Drop_Err is set, and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH. Count saturates 0..DEPTH by construction.
- Sticky_Flags |= captured flags on every capture, including dropped ones.
- Flags_Clear in the same cycle as a capture: the result is 0 | new flags, i.e. new flags win. Same rule applies to Drop_Err.
- Res_Data/Res_Flags are don't-care when Res_Valid=0. They hold stable while Res_Valid & !Res_Ready.
- States per FIFO: EMPTY (Count=0), PARTIAL, FULL (Count=DEPTH). Transitions follow push/pop only.

Optional Feature:
FPU_RES_OPTAG_EN:
- Defined: Issue_Op is piped LATENCY stages, stored per FIFO entry, and driven on Res_Op.
- Undefined: Res_Op port is absent, with no op pipe or op storage. Issue_Op is ignored.

Decomposition:
- Package fpu_pkg:
  - FLAG_W=3
  - flag bit indices FLG_EXC=2, FLG_OVF=1, FLG_UNF=0
  - op codes OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3
  - result-entry struct {data, flags, op}
- Sub-module fpu_res_fifo: parameterised show-ahead sync FIFO with push/pop/count. The collector instantiates it and owns the valid pipe, credit logic and sticky flags.

Test Plan:
- Reset then single op: Issue_Valid at t with Issue_Op=0; FPU_Output=0x40973333, flags 000 at t+1. Expect Res_Valid=1 at t+2 with Res_Data=0x40973333, Res_Flags=000, Count=1. Expect Res_Op=0 with the macro.
- Back-pressure fill: Res_Ready=0 and issue every cycle. Issue_Ready drops after 4 issues (Count+Inflight=4). Count reaches 4; Drop_Err stays 0. Then Res_Ready=1: data drains in order.
- Full with simultaneous push/pop: Count=4, capture and pop in the same cycle. Expect Count=4, new entry at the tail, Drop_Err=0.
- Forced drop: ignore Issue_Ready with FIFO full and no pop, FPU_Output=0x7F800000. Expect Drop_Err=1, FIFO unchanged, and Sticky_Flags updated from the dropped result's flags.
- Sticky flags: capture flags 010 (Overflow), then 001. Expect Sticky=011. Pulse Flags_Clear together with a capture of flags 100: expect Sticky=100.
- Async reset mid-flight: assert Rst between Issue_Valid and capture with Count=2. Expect Count=0, Res_Valid=0, Sticky=000 immediately. No capture after Rst is released.
